packetizer: RTL and testbench

PACKETIZER -- requirements
Module: packetizer

---
 rtl/packetizer.sv | 204 ++++++++++++++++++++
 tb/tb_packetizer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer.sv
// -----------------------------------------------------------------------------
// packetizer
//
// Wraps a stream of payload words from a core into NoC packets for a mesh
// router. Each packet starts with a header flit that carries the destination
// and source router coordinates. Up to MAX_BODY payload words follow the
// header. A message longer than MAX_BODY words is split across several
// packets. Every packet after the first reuses the destination latched at
// the start of the message.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : synchronous active-low reset
//   s_tdata    : payload word from the core
//   s_tvalid   : payload word valid
//   s_tready   : packetizer accepts the payload word
//   s_tlast    : last payload word of the message
//   dest_x     : destination column, valid with the first word of a message
//   dest_y     : destination row, valid with the first word of a message
//   m_tdata    : flit to the router input queue
//   m_tvalid   : flit valid
//   m_tlast    : last flit of the current packet
//   m_tready   : router queue ready
//   busy       : packetizer is inside a packet (not IDLE)
// -----------------------------------------------------------------------------
module packetizer #(
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_ROUTERS_X           = 4,
    parameter int MAX_ROUTERS_Y           = 4,
    parameter int ROUTER_X                = 0,
    parameter int ROUTER_Y                = 0,
    parameter int MAXIMUM_PACKAGES_NUMBER = 5,
    parameter int MAX_ROUTERS_X_WIDTH     = $clog2(MAX_ROUTERS_X),
    parameter int MAX_ROUTERS_Y_WIDTH     = $clog2(MAX_ROUTERS_Y)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          s_tdata,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    input  logic                           s_tlast,
    input  logic [MAX_ROUTERS_X_WIDTH-1:0] dest_x,
    input  logic [MAX_ROUTERS_Y_WIDTH-1:0] dest_y,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic                           m_tvalid,
    output logic                           m_tlast,
    input  logic                           m_tready,
    output logic                           busy
);

    localparam int XW       = MAX_ROUTERS_X_WIDTH;
    localparam int YW       = MAX_ROUTERS_Y_WIDTH;
    // A packet always has room for at least one body word.
    localparam int MAX_BODY = (MAXIMUM_PACKAGES_NUMBER > 1) ? (MAXIMUM_PACKAGES_NUMBER - 1) : 1;
    localparam int CNT_W    = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BODY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XW-1:0]    SRC_X    = XW'(ROUTER_X);
    localparam logic [YW-1:0]    SRC_Y    = YW'(ROUTER_Y);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_BODY   = 2'd2;

    // The header packs dest_x, dest_y, src_x and src_y, starting at bit 0.
    // All higher bits are zero.
    function automatic logic [DATA_WIDTH-1:0] build_header(
        input logic [XW-1:0] dx,
        input logic [YW-1:0] dy
    );
        logic [DATA_WIDTH-1:0] hdr;
        hdr                            = {DATA_WIDTH{1'b0}};
        hdr[XW-1:0]                    = dx;
        hdr[XW+YW-1:XW]                = dy;
        hdr[2*XW+YW-1:XW+YW]           = SRC_X;
        hdr[2*XW+2*YW-1:2*XW+YW]       = SRC_Y;
        return hdr;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [XW-1:0]         dest_x_r;
    logic [XW-1:0]         dest_x_nxt_s;
    logic [YW-1:0]         dest_y_r;
    logic [YW-1:0]         dest_y_nxt_s;
    logic [DATA_WIDTH-1:0] header_s;
    logic                  beat_s;
    logic                  cnt_at_last_s;

    assign header_s      = build_header(dest_x_r, dest_y_r);
    assign beat_s        = s_tvalid & m_tready;
    assign cnt_at_last_s = (cnt_r == CNT_LAST);

    // Next-state, body counter and destination latch.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        dest_x_nxt_s = dest_x_r;
        dest_y_nxt_s = dest_y_r;
        case (state_r)
            ST_IDLE: begin
                // The first word only opens the message. It stays on s_tdata
                // until the header has been sent.
                if (s_tvalid) begin
                    state_nxt_s  = ST_HEADER;
                    dest_x_nxt_s = dest_x;
                    dest_y_nxt_s = dest_y;
                    cnt_nxt_s    = CNT_ZERO;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (m_tready) begin
                    state_nxt_s = ST_BODY;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_HEADER;
                end
            end
            ST_BODY: begin
                if (beat_s) begin
                    if (s_tlast) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_at_last_s) begin
                        // The packet is full. The message continues behind a
                        // fresh header that uses the same latched destination.
                        state_nxt_s = ST_HEADER;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_BODY;
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                cnt_nxt_s    = CNT_ZERO;
                dest_x_nxt_s = {XW{1'b0}};
                dest_y_nxt_s = {YW{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            dest_x_r <= {XW{1'b0}};
            dest_y_r <= {YW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            dest_x_r <= dest_x_nxt_s;
            dest_y_r <= dest_y_nxt_s;
        end
    end

    // Output decode. The body is a zero-latency pass-through, so the flit
    // outputs depend on the live handshake inputs while in BODY.
    always_comb begin
        m_tdata  = {DATA_WIDTH{1'b0}};
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = 1'b0;
        case (state_r)
            ST_IDLE: begin
                m_tdata  = {DATA_WIDTH{1'b0}};
                m_tvalid = 1'b0;
                m_tlast  = 1'b0;
                s_tready = 1'b0;
            end
            ST_HEADER: begin
                m_tdata  = header_s;
                m_tvalid = 1'b1;
                m_tlast  = 1'b0;
                s_tready = 1'b0;
            end
            ST_BODY: begin
                m_tdata  = s_tdata;
                m_tvalid = s_tvalid;
                m_tlast  = s_tlast | cnt_at_last_s;
                s_tready = m_tready;
            end
            default: begin
                m_tdata  = {DATA_WIDTH{1'b0}};
                m_tvalid = 1'b0;
                m_tlast  = 1'b0;
                s_tready = 1'b0;
            end
        endcase
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_packetizer.sv
module tb_packetizer;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [1:0]  dest_x;
    logic [1:0]  dest_y;
    logic        m_tready;

    logic        s_tready0, m_tvalid0, m_tlast0, busy0;
    logic [31:0] m_tdata0;
    logic        s_tready1, m_tvalid1, m_tlast1, busy1;
    logic [31:0] m_tdata1;

    int checks = 0;
    int errors = 0;

    // Main DUT: 4x4 mesh, source (1,2), up to 4 body words per packet.
    packetizer #(
        .DATA_WIDTH(32), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
        .ROUTER_X(1), .ROUTER_Y(2), .MAXIMUM_PACKAGES_NUMBER(5)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready0), .s_tlast(s_tlast), .dest_x(dest_x), .dest_y(dest_y),
        .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tlast(m_tlast0),
        .m_tready(m_tready), .busy(busy0)
    );

    // Second DUT: one body word per packet.
    packetizer #(
        .DATA_WIDTH(32), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
        .ROUTER_X(1), .ROUTER_Y(2), .MAXIMUM_PACKAGES_NUMBER(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready1), .s_tlast(s_tlast), .dest_x(dest_x), .dest_y(dest_y),
        .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tlast(m_tlast1),
        .m_tready(m_tready), .busy(busy1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic [31:0] d;
        logic        v;
        logic        l;
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic        rdy;
        logic [31:0] e_d;
        logic        e_v;
        logic        e_l;
        logic        e_sr;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic r, input logic [31:0] d, input logic v, input logic l,
        input logic [1:0] dx, input logic [1:0] dy, input logic rdy,
        input logic [31:0] e_d, input logic e_v, input logic e_l,
        input logic e_sr, input logic e_busy
    );
        vec_t t;
        t.rst_n = r; t.d = d; t.v = v; t.l = l; t.dx = dx; t.dy = dy; t.rdy = rdy;
        t.e_d = e_d; t.e_v = e_v; t.e_l = e_l; t.e_sr = e_sr; t.e_busy = e_busy;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] d, input logic v, input logic l,
                         input logic [1:0] dx, input logic [1:0] dy, input logic rdy);
        rst_n = r; s_tdata = d; s_tvalid = v; s_tlast = l;
        dest_x = dx; dest_y = dy; m_tready = rdy;
    endtask

    // Move to the next cycle and drive just after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table (dut0) ----------------
        // reset state
        add(1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        // 2-word message, dest (3,0): header 0x93
        add(1'b1, 32'hA,   1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'hA,   1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h93,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'hA,   1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'hA,   1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'hB,   1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 32'hB,   1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        // 6-word message with a split after 4 words; dest changes mid-message
        add(1'b1, 32'h100, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h100, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h93,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h100, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h101, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h101, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h102, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h102, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h103, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h103, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 32'h104, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h93,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h104, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h105, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 32'h105, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        // backpressure: 3-cycle stall on header and on body beat 2, dest (2,1) -> 0x96
        add(1'b1, 32'h200, 1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h200, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 32'h96,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h200, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 32'h96,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h200, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 32'h96,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h200, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 32'h96,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h200, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h201, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h201, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h201, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h201, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h201, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h201, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h201, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h201, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h202, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h202, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h203, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h203, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 32'h204, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 32'h96,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h204, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 32'h204, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        // s_tvalid gaps of 2 cycles, dest (1,3) -> 0x9D
        add(1'b1, 32'h300, 1'b1, 1'b0, 2'd1, 2'd3, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h300, 1'b1, 1'b0, 2'd1, 2'd3, 1'b1, 32'h9D,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h300, 1'b1, 1'b0, 2'd1, 2'd3, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h301, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 32'h301, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h302, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 32'h302, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        // reset after header + 1 body flit, then a fresh message to (2,1)
        add(1'b1, 32'h400, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h400, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h93,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h400, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b0, 32'h401, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h401, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h500, 1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h500, 1'b1, 1'b1, 2'd2, 2'd1, 1'b1, 32'h96,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h500, 1'b1, 1'b1, 2'd2, 2'd1, 1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);

        // initial reset so that both DUTs start from a known state
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        next_cycle();
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].d, vecs[i].v, vecs[i].l,
                  vecs[i].dx, vecs[i].dy, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("v%0d m_tdata", i),  m_tdata0,  vecs[i].e_d);
            check($sformatf("v%0d m_tvalid", i), {31'd0, m_tvalid0}, {31'd0, vecs[i].e_v});
            check($sformatf("v%0d m_tlast", i),  {31'd0, m_tlast0},  {31'd0, vecs[i].e_l});
            check($sformatf("v%0d s_tready", i), {31'd0, s_tready0}, {31'd0, vecs[i].e_sr});
            check($sformatf("v%0d busy", i),     {31'd0, busy0},     {31'd0, vecs[i].e_busy});
            next_cycle();
        end

        // ---------------- hand sequence: one body word per packet (dut1) ----------------
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        next_cycle();
        // single-word message with s_tlast
        drive(1'b1, 32'h77, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1);
        @(negedge clk);
        check("mb1 idle m_tvalid", {31'd0, m_tvalid1}, 32'd0);
        check("mb1 idle s_tready", {31'd0, s_tready1}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("mb1 header data",  m_tdata1, 32'h93);
        check("mb1 header valid", {31'd0, m_tvalid1}, 32'd1);
        check("mb1 header last",  {31'd0, m_tlast1},  32'd0);
        next_cycle();
        @(negedge clk);
        check("mb1 word data",   m_tdata1, 32'h77);
        check("mb1 word last",   {31'd0, m_tlast1},  32'd1);
        check("mb1 word sready", {31'd0, s_tready1}, 32'd1);
        next_cycle();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("mb1 after idle%0d valid", k), {31'd0, m_tvalid1}, 32'd0);
            check($sformatf("mb1 after idle%0d busy", k),  {31'd0, busy1},     32'd0);
            next_cycle();
        end
        // two-word message: split after every word
        drive(1'b1, 32'h88, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1);
        next_cycle();
        @(negedge clk);
        check("mb1 split hdr1", m_tdata1, 32'h93);
        next_cycle();
        @(negedge clk);
        check("mb1 split w0 data", m_tdata1, 32'h88);
        check("mb1 split w0 last", {31'd0, m_tlast1}, 32'd1);
        next_cycle();
        drive(1'b1, 32'h89, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        check("mb1 split hdr2", m_tdata1, 32'h93);
        check("mb1 split hdr2 busy", {31'd0, busy1}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("mb1 split w1 data", m_tdata1, 32'h89);
        check("mb1 split w1 last", {31'd0, m_tlast1}, 32'd1);
        next_cycle();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        check("mb1 split end busy", {31'd0, busy1}, 32'd0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
